// File: rtl/clock_pkg.sv
// Shared states, edit-field codes, 12-hour limits and wrap helpers for time_setter.
package clock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EDIT_HOUR = 3'd1,
        ST_EDIT_MIN  = 3'd2,
        ST_EDIT_AMPM = 3'd3,
        ST_COMMIT    = 3'd4
    } state_t;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_AMPM = 2'd3;

    localparam logic [3:0] HOUR_MIN = 4'd1;
    localparam logic [3:0] HOUR_MAX = 4'd12;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic       AM       = 1'b0;
    localparam logic       PM       = 1'b1;

    // Out-of-range inputs fall onto the nearest wrap point instead of drifting.
    function automatic logic [3:0] hour_step(input logic [3:0] h, input logic up);
        if (up) return (h >= HOUR_MAX) ? HOUR_MIN : h + 4'd1;
        else    return (h <= HOUR_MIN) ? HOUR_MAX : h - 4'd1;
    endfunction

    function automatic logic [5:0] min_step(input logic [5:0] m, input logic up);
        if (up) return (m >= MIN_MAX) ? 6'd0 : m + 6'd1;
        else    return (m == 6'd0 || m > MIN_MAX) ? MIN_MAX : m - 6'd1;
    endfunction

endpackage

// File: rtl/time_setter_if.sv
// Bus between time_setter (master) and the clock core (slave).
// Commit protocol: set_hour/set_minute/set_am_pm are valid one cycle before and during
// the single-cycle set_time pulse; there is no back-pressure. alarm_* are held levels.
interface time_setter_if;
    logic [3:0] hours;
    logic [5:0] minutes;
    logic       am_pm;
    logic       set_time;
    logic [3:0] set_hour;
    logic [5:0] set_minute;
    logic       set_am_pm;
    logic [3:0] alarm_hour;
    logic [5:0] alarm_minute;
    logic       alarm_am_pm;

    modport master (
        input  hours, minutes, am_pm,
        output set_time, set_hour, set_minute, set_am_pm,
        output alarm_hour, alarm_minute, alarm_am_pm
    );

    modport slave (
        output hours, minutes, am_pm,
        input  set_time, set_hour, set_minute, set_am_pm,
        input  alarm_hour, alarm_minute, alarm_am_pm
    );
endinterface

// File: rtl/time_setter_btn_edge_repeat.sv
// Button edge detector with hold counter: pulse_o fires on the rising edge and then
// every cycle once the button has been held for REPEAT_DELAY further cycles.
module btn_edge_repeat #(
    parameter int unsigned REPEAT_DELAY = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic edge_o,
    output logic pulse_o
);
    localparam int unsigned   CW    = $clog2(REPEAT_DELAY + 2);
    localparam logic [CW-1:0] DELAY = CW'(REPEAT_DELAY);

    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        edge_o = btn_i & ~prev_q;
        cnt_d  = cnt_q;
        if (!btn_i || edge_o) cnt_d = '0;
        else if (cnt_q < DELAY) cnt_d = cnt_q + CW'(1);
        pulse_o = edge_o | (btn_i & prev_q & (cnt_q == DELAY));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= btn_i;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/time_setter.sv
// Front-panel time/alarm editor driving the clock core's set-time and alarm inputs.
// Optional decrement button is enabled by defining TIMESET_DEC_EN.
module time_setter
    import clock_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 2,
    parameter int unsigned TIMEOUT      = 10
) (
    input  logic          clock_sec,
    input  logic          reset,
    input  logic          btn_mode,
    input  logic          btn_inc,
`ifdef TIMESET_DEC_EN
    input  logic          btn_dec,
`endif
    input  logic          btn_confirm,
    input  logic          btn_cancel,
    input  logic          alarm_sel,
    time_setter_if.master core,
    output logic          editing,
    output logic [1:0]    edit_field,
    output state_t        dbg_state_o
);
    localparam int unsigned   IW        = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          target_q, target_d;
    logic [3:0]    wh_q, wh_d;
    logic [5:0]    wm_q, wm_d;
    logic          wa_q, wa_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          set_time_q, set_time_d;
    logic [3:0]    set_hour_q, set_hour_d;
    logic [5:0]    set_min_q, set_min_d;
    logic          set_ampm_q, set_ampm_d;
    logic [3:0]    al_hour_q, al_hour_d;
    logic [5:0]    al_min_q, al_min_d;
    logic          al_ampm_q, al_ampm_d;
    logic          mode_prev_q, conf_prev_q, cancel_prev_q;

    logic mode_ev, conf_ev, cancel_ev, any_ev;
    logic inc_edge, inc_pulse, step_up, step_dn;

    btn_edge_repeat #(.REPEAT_DELAY(REPEAT_DELAY)) u_inc (
        .clk_i(clock_sec), .rst_i(reset), .btn_i(btn_inc),
        .edge_o(inc_edge), .pulse_o(inc_pulse)
    );

`ifdef TIMESET_DEC_EN
    logic dec_edge, dec_pulse;
    btn_edge_repeat #(.REPEAT_DELAY(REPEAT_DELAY)) u_dec (
        .clk_i(clock_sec), .rst_i(reset), .btn_i(btn_dec),
        .edge_o(dec_edge), .pulse_o(dec_pulse)
    );
    // Simultaneous inc and dec steps cancel out.
    assign step_up = inc_pulse & ~dec_pulse;
    assign step_dn = dec_pulse & ~inc_pulse;
    assign any_ev  = mode_ev | conf_ev | cancel_ev | inc_edge | dec_edge;
`else
    assign step_up = inc_pulse;
    assign step_dn = 1'b0;
    assign any_ev  = mode_ev | conf_ev | cancel_ev | inc_edge;
`endif

    assign mode_ev   = btn_mode    & ~mode_prev_q;
    assign conf_ev   = btn_confirm & ~conf_prev_q;
    assign cancel_ev = btn_cancel  & ~cancel_prev_q;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        wh_d       = wh_q;
        wm_d       = wm_q;
        wa_d       = wa_q;
        idle_d     = idle_q;
        set_time_d = 1'b0;
        set_hour_d = set_hour_q;
        set_min_d  = set_min_q;
        set_ampm_d = set_ampm_q;
        al_hour_d  = al_hour_q;
        al_min_d   = al_min_q;
        al_ampm_d  = al_ampm_q;

        case (state_q)
            ST_IDLE: begin
                idle_d = '0;
                if (mode_ev) begin
                    target_d = alarm_sel;
                    wh_d     = alarm_sel ? al_hour_q : core.hours;
                    wm_d     = alarm_sel ? al_min_q  : core.minutes;
                    wa_d     = alarm_sel ? al_ampm_q : core.am_pm;
                    state_d  = ST_EDIT_HOUR;
                end
            end
            ST_EDIT_HOUR, ST_EDIT_MIN, ST_EDIT_AMPM: begin
                idle_d = any_ev ? '0 : idle_q + IW'(1);
                if (cancel_ev) begin
                    state_d = ST_IDLE;
                end else if (conf_ev) begin
                    if (target_q) begin
                        al_hour_d = wh_q;
                        al_min_d  = wm_q;
                        al_ampm_d = wa_q;
                    end else begin
                        set_hour_d = wh_q;
                        set_min_d  = wm_q;
                        set_ampm_d = wa_q;
                    end
                    state_d = ST_COMMIT;
                end else if (mode_ev) begin
                    case (state_q)
                        ST_EDIT_HOUR: state_d = ST_EDIT_MIN;
                        ST_EDIT_MIN:  state_d = ST_EDIT_AMPM;
                        default:      state_d = ST_EDIT_HOUR;
                    endcase
                end else if (!any_ev && idle_q == IDLE_LAST) begin
                    state_d = ST_IDLE;
                end else if (step_up || step_dn) begin
                    case (state_q)
                        ST_EDIT_HOUR: wh_d = hour_step(wh_q, step_up);
                        ST_EDIT_MIN:  wm_d = min_step(wm_q, step_up);
                        default:      wa_d = ~wa_q;
                    endcase
                end
            end
            ST_COMMIT: begin
                // set_* were loaded on entry, so the pulse lands a cycle after them.
                set_time_d = ~target_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_sec) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            target_q      <= 1'b0;
            wh_q          <= HOUR_MAX;
            wm_q          <= 6'd0;
            wa_q          <= AM;
            idle_q        <= '0;
            set_time_q    <= 1'b0;
            set_hour_q    <= HOUR_MAX;
            set_min_q     <= 6'd0;
            set_ampm_q    <= AM;
            al_hour_q     <= HOUR_MAX;
            al_min_q      <= 6'd0;
            al_ampm_q     <= AM;
            mode_prev_q   <= 1'b0;
            conf_prev_q   <= 1'b0;
            cancel_prev_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            wh_q          <= wh_d;
            wm_q          <= wm_d;
            wa_q          <= wa_d;
            idle_q        <= idle_d;
            set_time_q    <= set_time_d;
            set_hour_q    <= set_hour_d;
            set_min_q     <= set_min_d;
            set_ampm_q    <= set_ampm_d;
            al_hour_q     <= al_hour_d;
            al_min_q      <= al_min_d;
            al_ampm_q     <= al_ampm_d;
            mode_prev_q   <= btn_mode;
            conf_prev_q   <= btn_confirm;
            cancel_prev_q <= btn_cancel;
        end
    end

    always_comb begin
        case (state_q)
            ST_EDIT_HOUR: edit_field = FIELD_HOUR;
            ST_EDIT_MIN:  edit_field = FIELD_MIN;
            ST_EDIT_AMPM: edit_field = FIELD_AMPM;
            default:      edit_field = FIELD_NONE;
        endcase
    end

    assign editing           = (state_q != ST_IDLE);
    assign dbg_state_o       = state_q;
    assign core.set_time     = set_time_q;
    assign core.set_hour     = set_hour_q;
    assign core.set_minute   = set_min_q;
    assign core.set_am_pm    = set_ampm_q;
    assign core.alarm_hour   = al_hour_q;
    assign core.alarm_minute = al_min_q;
    assign core.alarm_am_pm  = al_ampm_q;
endmodule

// File: tb/tb_time_setter.sv
// Self-checking bench for time_setter: directed scenarios plus randomized buttons
// against an event-level behavioural model and a commit scoreboard.
module tb_time_setter;
    import clock_pkg::*;

    localparam int REPEAT_DELAY = 2;
    localparam int TIMEOUT      = 10;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic b_mode, b_inc, b_dec, b_confirm, b_cancel, b_alarm_sel;
    logic       d_editing;
    logic [1:0] d_field;
    state_t     d_state;

    time_setter_if core_if();

    time_setter #(.REPEAT_DELAY(REPEAT_DELAY), .TIMEOUT(TIMEOUT)) dut (
        .clock_sec   (clk),
        .reset       (rst),
        .btn_mode    (b_mode),
        .btn_inc     (b_inc),
`ifdef TIMESET_DEC_EN
        .btn_dec     (b_dec),
`endif
        .btn_confirm (b_confirm),
        .btn_cancel  (b_cancel),
        .alarm_sel   (b_alarm_sel),
        .core        (core_if),
        .editing     (d_editing),
        .edit_field  (d_field),
        .dbg_state_o (d_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_st: 0 idle, 1 hour, 2 minute, 3 am/pm, 4 commit
    int m_st, m_tgt, m_wh, m_wm, m_wa, m_quiet, m_inc_len, m_dec_len;
    int m_p_mode, m_p_conf, m_p_cancel;
    int e_set_time, e_set_hour, e_set_min, e_set_ampm, e_al_hour, e_al_min, e_al_ampm;
    logic [10:0] exp_q[$];
    bit started = 0;

    task automatic bump(input int d);
        case (m_st)
            1: m_wh = ((m_wh - 1 + d + 12) % 12) + 1;
            2: m_wm = (m_wm + d + 60) % 60;
            default: m_wa = 1 - m_wa;
        endcase
    endtask

    task automatic model_step();
        bit ev_mode, ev_conf, ev_cancel, inc_edge, dec_edge, inc_act, dec_act, any_ev;
        if (rst) begin
            m_st = 0; m_tgt = 0; m_wh = 12; m_wm = 0; m_wa = 0; m_quiet = 0;
            m_inc_len = 0; m_dec_len = 0; m_p_mode = 0; m_p_conf = 0; m_p_cancel = 0;
            e_set_time = 0; e_set_hour = 12; e_set_min = 0; e_set_ampm = 0;
            e_al_hour = 12; e_al_min = 0; e_al_ampm = 0;
            exp_q.delete();
            return;
        end
        ev_mode   = b_mode    && (m_p_mode == 0);
        ev_conf   = b_confirm && (m_p_conf == 0);
        ev_cancel = b_cancel  && (m_p_cancel == 0);
        m_p_mode = int'(b_mode); m_p_conf = int'(b_confirm); m_p_cancel = int'(b_cancel);
        m_inc_len = b_inc ? m_inc_len + 1 : 0;
        inc_edge  = (m_inc_len == 1);
        inc_act   = inc_edge || (m_inc_len >= REPEAT_DELAY + 2);
`ifdef TIMESET_DEC_EN
        m_dec_len = b_dec ? m_dec_len + 1 : 0;
`endif
        dec_edge  = (m_dec_len == 1);
        dec_act   = dec_edge || (m_dec_len >= REPEAT_DELAY + 2);
        any_ev    = ev_mode || ev_conf || ev_cancel || inc_edge || dec_edge;
        e_set_time = 0;
        case (m_st)
            0: if (ev_mode) begin
                m_tgt = int'(b_alarm_sel);
                if (m_tgt != 0) begin
                    m_wh = e_al_hour; m_wm = e_al_min; m_wa = e_al_ampm;
                end else begin
                    m_wh = int'(core_if.hours); m_wm = int'(core_if.minutes); m_wa = int'(core_if.am_pm);
                end
                m_quiet = 0;
                m_st = 1;
            end
            1, 2, 3: begin
                m_quiet = any_ev ? 0 : m_quiet + 1;
                if (ev_cancel) m_st = 0;
                else if (ev_conf) begin
                    if (m_tgt != 0) begin
                        e_al_hour = m_wh; e_al_min = m_wm; e_al_ampm = m_wa;
                    end else begin
                        e_set_hour = m_wh; e_set_min = m_wm; e_set_ampm = m_wa;
                        exp_q.push_back(11'(m_wh * 128 + m_wm * 2 + m_wa));
                    end
                    m_st = 4;
                end
                else if (ev_mode) m_st = (m_st % 3) + 1;
                else if (m_quiet >= TIMEOUT) m_st = 0;
                else if (inc_act && !dec_act) bump(1);
                else if (dec_act && !inc_act) bump(-1);
            end
            default: begin
                e_set_time = (m_tgt == 0) ? 1 : 0;
                m_st = 0;
            end
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        started = 1;
    end

    // ---------------- per-cycle compare + scoreboard ----------------
    initial forever begin
        @(negedge clk);
        if (started) begin
            logic [10:0] got, exp;
            chk("editing",      int'(d_editing), int'(m_st != 0));
            chk("edit_field",   int'(d_field), (m_st >= 1 && m_st <= 3) ? m_st : 0);
            chk("dbg_idle",     int'(d_state == ST_IDLE), int'(m_st == 0));
            chk("set_time",     int'(core_if.set_time), e_set_time);
            chk("set_hour",     int'(core_if.set_hour), e_set_hour);
            chk("set_minute",   int'(core_if.set_minute), e_set_min);
            chk("set_am_pm",    int'(core_if.set_am_pm), e_set_ampm);
            chk("alarm_hour",   int'(core_if.alarm_hour), e_al_hour);
            chk("alarm_minute", int'(core_if.alarm_minute), e_al_min);
            chk("alarm_am_pm",  int'(core_if.alarm_am_pm), e_al_ampm);
            if (core_if.set_time) begin
                got = {core_if.set_hour, core_if.set_minute, core_if.set_am_pm};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_commit: got pulse with value %0d, expected no pulse (t=%0t)", got, $time);
                end else begin
                    exp = exp_q.pop_front();
                    chk("sb_commit", int'(got), int'(exp));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: b_mode = v;
            1: b_inc = v;
            2: b_confirm = v;
            default: b_cancel = v;
        endcase
    endtask

    task automatic press(input int which);
        set_btn(which, 1'b1);
        cyc();
        set_btn(which, 1'b0);
        cyc();
    endtask

    task automatic set_core(input int h, input int m, input int a);
        core_if.hours   = 4'(h);
        core_if.minutes = 6'(m);
        core_if.am_pm   = 1'(a);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_set_time"}, int'(core_if.set_time), 0);
        chk({tag, "_set_hour"}, int'(core_if.set_hour), 12);
        chk({tag, "_set_minute"}, int'(core_if.set_minute), 0);
        chk({tag, "_set_am_pm"}, int'(core_if.set_am_pm), 0);
        chk({tag, "_alarm_hour"}, int'(core_if.alarm_hour), 12);
        chk({tag, "_alarm_minute"}, int'(core_if.alarm_minute), 0);
        chk({tag, "_alarm_am_pm"}, int'(core_if.alarm_am_pm), 0);
        chk({tag, "_editing"}, int'(d_editing), 0);
        chk({tag, "_edit_field"}, int'(d_field), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        b_mode = 0; b_inc = 0; b_dec = 0; b_confirm = 0; b_cancel = 0; b_alarm_sel = 0;
        set_core(3, 45, 1);
        cyc();
        cyc();
        rst = 1'b0;
        chk_reset_vals("reset");

        // Time edit: 3:45 PM, two incs -> 5:45 PM
        press(0);
        press(1);
        press(1);
        b_confirm = 1'b1;
        cyc();
        chk("t1_hour_before_pulse", int'(core_if.set_hour), 5);
        chk("t1_no_pulse_yet", int'(core_if.set_time), 0);
        b_confirm = 1'b0;
        cyc();
        chk("t1_pulse", int'(core_if.set_time), 1);
        chk("t1_minute", int'(core_if.set_minute), 45);
        chk("t1_am_pm", int'(core_if.set_am_pm), 1);
        cyc();
        chk("t1_pulse_end", int'(core_if.set_time), 0);
        chk("t1_idle", int'(d_editing), 0);

        // Wrap: 12 -> 1, 59 -> 0
        set_core(12, 59, 0);
        press(0);
        press(1);
        chk("t2_field_hour", int'(d_field), 1);
        press(0);
        chk("t2_field_min", int'(d_field), 2);
        press(1);
        press(2);
        chk("t2_pulse", int'(core_if.set_time), 1);
        chk("t2_hour", int'(core_if.set_hour), 1);
        chk("t2_minute", int'(core_if.set_minute), 0);
        chk("t2_am_pm", int'(core_if.set_am_pm), 0);
        cyc();

        // Alarm edit: minute +5 from 12:00 AM
        b_alarm_sel = 1'b1;
        press(0);
        b_alarm_sel = 1'b0;
        press(0);
        repeat (5) press(1);
        press(2);
        chk("t3_alarm_minute", int'(core_if.alarm_minute), 5);
        chk("t3_alarm_hour", int'(core_if.alarm_hour), 12);
        chk("t3_no_pulse", int'(core_if.set_time), 0);
        chk("t3_set_hour_kept", int'(core_if.set_hour), 1);

        // Auto-repeat: minute 10, inc held 6 cycles -> 14
        set_core(2, 10, 0);
        press(0);
        press(0);
        b_inc = 1'b1;
        repeat (6) cyc();
        b_inc = 1'b0;
        repeat (3) cyc();
        press(2);
        chk("t4_minute", int'(core_if.set_minute), 14);
        chk("t4_hour", int'(core_if.set_hour), 2);
        cyc();

        // Cancel after editing hour to 7
        set_core(6, 30, 1);
        press(0);
        press(1);
        press(3);
        chk("t5_cancel_idle", int'(d_editing), 0);
        chk("t5_cancel_hour", int'(core_if.set_hour), 2);
        chk("t5_cancel_no_pulse", int'(core_if.set_time), 0);

        // Timeout: no buttons after entry
        press(0);
        repeat (TIMEOUT - 2) cyc();
        chk("t5_before_timeout", int'(d_editing), 1);
        cyc();
        chk("t5_timeout_idle", int'(d_editing), 0);
        chk("t5_timeout_hour", int'(core_if.set_hour), 2);

        // Confirm and cancel together: cancel wins
        press(0);
        press(1);
        b_confirm = 1'b1;
        b_cancel  = 1'b1;
        cyc();
        chk("t6_prio_idle", int'(d_editing), 0);
        b_confirm = 1'b0;
        b_cancel  = 1'b0;
        cyc();
        chk("t6_prio_no_pulse", int'(core_if.set_time), 0);
        chk("t6_prio_hour", int'(core_if.set_hour), 2);

        // Reset mid-edit
        press(0);
        press(1);
        rst = 1'b1;
        cyc();
        chk_reset_vals("t6_midreset");
        rst = 1'b0;
        cyc();

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 399) == 0);
            b_mode      = b_mode    ? ($urandom_range(0, 1) == 0)  : ($urandom_range(0, 7) == 0);
            b_confirm   = b_confirm ? ($urandom_range(0, 1) == 0)  : ($urandom_range(0, 29) == 0);
            b_cancel    = b_cancel  ? ($urandom_range(0, 1) == 0)  : ($urandom_range(0, 49) == 0);
            b_inc       = b_inc     ? ($urandom_range(0, 5) != 0)  : ($urandom_range(0, 4) == 0);
`ifdef TIMESET_DEC_EN
            b_dec       = b_dec     ? ($urandom_range(0, 5) != 0)  : ($urandom_range(0, 5) == 0);
`endif
            b_alarm_sel = 1'($urandom_range(0, 1));
            if (c % 4 == 0)
                set_core(int'($urandom_range(1, 12)), int'($urandom_range(0, 59)), int'($urandom_range(0, 1)));
            cyc();
        end

        rst = 1'b0;
        b_mode = 0; b_inc = 0; b_dec = 0; b_confirm = 0; b_cancel = 0;
        repeat (4) cyc();
        chk("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
